// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: IF/ID latch layout, fetch FSM states and opcode constants.
// Pure declarations; no logic or timing of its own.
package instr_fetch_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OP_HALT   = 5'b00000;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
  } ifid_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// 33-bit pipeline latch (instr, pc+2, valid): bubble beats load, otherwise holds.
// One-cycle latency; the caller holds it by deasserting both load and bubble.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '{instr: NOP_INSTR, pc_plus2: 16'h0000, valid: 1'b0};
    end else if (bubble) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads a variable-latency imem, feeds the IF/ID latch.
// Zero-wait memory gives 1 instr/cycle; a stalled response parks in a one-entry skid buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid,
  output logic        if_HALT,
  output logic        err
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  drain_addr;
  logic [15:0]  buf_instr;
  logic [15:0]  buf_pc2;
  logic [15:0]  pc_inc;
  logic [15:0]  target;
  logic         accept;
  logic         ifid_load;
  logic         ifid_bubble;
  ifid_t        ifid_d;
  ifid_t        ifid_q;

  assign imem_req  = rst && (state == REQ || state == DRAIN);
  // DRAIN must keep presenting the abandoned address until memory answers it.
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign accept    = imem_req && imem_ready;
  assign pc_inc    = pc + 16'd2;
  assign target    = {redirect_pc[15:1], 1'b0};

  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_d      = '{instr: imem_rdata, pc_plus2: pc_inc, valid: 1'b1};
    if (redirect) begin
      ifid_bubble = 1'b1;
    end else begin
      case (state)
        REQ: begin
          if (!stall) begin
            ifid_load   = accept;
            ifid_bubble = !accept;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load = 1'b1;
            ifid_d    = '{instr: buf_instr, pc_plus2: buf_pc2, valid: 1'b1};
          end
        end
        HALTED: ifid_bubble = !stall;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      drain_addr <= 16'h0000;
      buf_instr  <= 16'h0000;
      buf_pc2    <= 16'h0000;
      err        <= 1'b0;
    end else begin
      if (redirect && redirect_pc[0]) err <= 1'b1;
      case (state)
        REQ: begin
          if (redirect) begin
            pc <= target;
            if (!accept) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end
          end else if (accept) begin
            pc <= pc_inc;
            if (stall) begin
              buf_instr <= imem_rdata;
              buf_pc2   <= pc_inc;
              state     <= HOLD;
            end else if (is_halt(imem_rdata)) begin
              state <= HALTED;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= REQ;
          end else if (!stall) begin
            state <= is_halt(buf_instr) ? HALTED : REQ;
          end
        end
        DRAIN: begin
          if (redirect) pc <= target;
          if (imem_ready) state <= REQ;
        end
        HALTED: begin
          if (redirect) begin
            pc    <= target;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign if_instr    = ifid_q.instr;
  assign if_pc_plus2 = ifid_q.pc_plus2;
  assign if_valid    = ifid_q.valid;
  assign if_HALT     = ifid_q.valid && is_halt(ifid_q.instr);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, directed corner sequences, then a randomized
// run scored against an in-order instruction-stream model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        if_valid;
  logic        if_HALT;
  logic        err;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .if_valid    (if_valid),
    .if_HALT     (if_HALT),
    .err         (err)
  );

  logic [15:0] mem [0:1023];
  int checks = 0;
  int failures = 0;
  int wait_cnt = 0;
  int cur_lat = 0;
  bit rand_lat = 0;
  bit model_on = 0;

  logic [15:0] exp_pc;
  logic [15:0] prev_addr;
  bit          prev_pend;
  bit          prev_redir;
  bit          ref_err;
  int          consumed;

  typedef struct {
    logic        st;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc2;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem[a[10:1]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h8000 | 16'($urandom_range(0, 32767));
    mem[0] = 16'hC001;
    mem[1] = 16'hC102;
    mem[2] = 16'hC203;
    mem[3] = 16'hC304;
  endtask

  // Memory answers after cur_lat waiting cycles; latency 0 answers in the request cycle.
  task automatic mem_drive();
    if (imem_req) begin
      if (wait_cnt == 0 && rand_lat) cur_lat = $urandom_range(0, 2);
      if (wait_cnt >= cur_lat) begin
        imem_ready = 1'b1;
        imem_rdata = rd_mem(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      imem_ready = rand_lat ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = 16'($urandom);
      wait_cnt   = 0;
    end
  endtask

  // Decode consumes IF/ID whenever it is valid and neither stalled nor redirected.
  task automatic model_cycle();
    logic [15:0] nxt;
    chk("rand_err", err, ref_err);
    if (prev_pend) begin
      chk("rand_req_hold", imem_req, 1'b1);
      chk("rand_addr_hold", imem_addr, prev_addr);
    end
    if (prev_redir) chk("rand_redir_bubble", if_valid, 1'b0);
    if (redirect) begin
      exp_pc  = {redirect_pc[15:1], 1'b0};
      ref_err = ref_err | redirect_pc[0];
    end else if (if_valid && !stall) begin
      nxt = exp_pc + 16'd2;
      chk("rand_instr", if_instr, rd_mem(exp_pc));
      chk("rand_pc2", if_pc_plus2, nxt);
      chk("rand_halt", if_HALT, 1'b0);
      exp_pc = nxt;
      consumed++;
    end
  endtask

  task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    if (model_on) model_cycle();
    mem_drive();
    if (model_on) begin
      prev_pend  = imem_req && !imem_ready;
      prev_addr  = imem_addr;
      prev_redir = rd;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    model_on = 0;
    rand_lat = 0;
    cur_lat  = 0;
    wait_cnt = 0;
    rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 16'h0800);
    chk("rst_pc2", if_pc_plus2, 16'h0000);
    chk("rst_err", err, 1'b0);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bit          found;
    logic        st;
    logic        rd;
    logic [15:0] rpc;

    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_ready = 1'b0; imem_rdata = 16'h0000;
    tbl[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'hC001, 16'h0002};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hC001, 16'h0002};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hC001, 16'h0002};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hC001, 16'h0002};
    tbl[5] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'hC102, 16'h0004};
    tbl[6] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'hC203, 16'h0006};
    tbl[7] = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'hC304, 16'h0008};
    fill_mem();
    @(negedge clk);

    // Zero-wait stream with a 3-cycle stall over the second accept
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_req", i), imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), if_valid, tbl[i].exp_valid);
      chk($sformatf("vec%0d_instr", i), if_instr, tbl[i].exp_instr);
      if (tbl[i].exp_valid) chk($sformatf("vec%0d_pc2", i), if_pc_plus2, tbl[i].exp_pc2);
      chk($sformatf("vec%0d_halt", i), if_HALT, 1'b0);
      step(tbl[i].st, 1'b0, 16'h0000);
    end

    // 3-cycle memory, redirect while the request at 0x0008 is outstanding
    do_reset();
    cur_lat = 2;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (imem_req && imem_addr == 16'h0008 && wait_cnt == 0) found = 1;
      else step(0, 0, 0);
    end
    chk("drain_reach_0008", found, 1'b1);
    step(0, 0, 0);
    chk("drain_addr_pre", imem_addr, 16'h0008);
    step(0, 1, 16'h0040);
    chk("drain_req", imem_req, 1'b1);
    chk("drain_addr_old", imem_addr, 16'h0008);
    chk("drain_valid0", if_valid, 1'b0);
    step(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain_new_addr%0d", k), imem_addr, 16'h0040);
      chk($sformatf("drain_new_valid%0d", k), if_valid, 1'b0);
      step(0, 0, 0);
    end
    chk("drain_tgt_valid", if_valid, 1'b1);
    chk("drain_tgt_instr", if_instr, rd_mem(16'h0040));
    chk("drain_tgt_pc2", if_pc_plus2, 16'h0042);

    // HALT word at 0x0006, then redirect out of HALTED
    do_reset();
    mem[3] = 16'h0000;
    for (int k = 0; k < 4; k++) step(0, 0, 0);
    chk("halt_flag", if_HALT, 1'b1);
    chk("halt_valid", if_valid, 1'b1);
    chk("halt_req", imem_req, 1'b0);
    step(1, 0, 0);
    chk("halt_flag_stalled", if_HALT, 1'b1);
    chk("halt_req_stalled", imem_req, 1'b0);
    step(0, 0, 0);
    chk("halt_clear_valid", if_valid, 1'b0);
    chk("halt_clear_flag", if_HALT, 1'b0);
    chk("halt_clear_instr", if_instr, 16'h0800);
    chk("halt_idle_req", imem_req, 1'b0);
    step(0, 0, 0);
    chk("halt_idle_req2", imem_req, 1'b0);
    step(0, 1, 16'h0010);
    chk("halt_resume_req", imem_req, 1'b1);
    chk("halt_resume_addr", imem_addr, 16'h0010);
    step(0, 0, 0);
    chk("halt_resume_instr", if_instr, rd_mem(16'h0010));
    chk("halt_resume_pc2", if_pc_plus2, 16'h0012);
    chk("halt_resume_flag", if_HALT, 1'b0);
    mem[3] = 16'hC304;

    // redirect + stall + ready together, then PC wrap at 0xFFFE
    do_reset();
    step(0, 0, 0);
    chk("rsr_addr", imem_addr, 16'h0002);
    step(1, 1, 16'h0020);
    chk("rsr_valid", if_valid, 1'b0);
    chk("rsr_instr", if_instr, 16'h0800);
    chk("rsr_addr_tgt", imem_addr, 16'h0020);
    step(0, 0, 0);
    chk("rsr_tgt_instr", if_instr, rd_mem(16'h0020));
    chk("rsr_tgt_pc2", if_pc_plus2, 16'h0022);
    step(0, 1, 16'hFFFE);
    chk("wrap_addr0", imem_addr, 16'hFFFE);
    step(0, 0, 0);
    chk("wrap_addr1", imem_addr, 16'h0000);
    chk("wrap_instr", if_instr, rd_mem(16'hFFFE));
    chk("wrap_pc2", if_pc_plus2, 16'h0000);

    // Misaligned redirect sets sticky err; only reset clears it
    do_reset();
    step(0, 1, 16'h0003);
    chk("err_set", err, 1'b1);
    chk("err_fetch_addr", imem_addr, 16'h0002);
    step(0, 0, 0);
    chk("err_fetch_instr", if_instr, 16'hC102);
    chk("err_fetch_pc2", if_pc_plus2, 16'h0004);
    for (int k = 0; k < 5; k++) step($urandom_range(0, 1) == 1, 0, 0);
    chk("err_sticky", err, 1'b1);
    rst = 1'b0;
    step(0, 0, 0);
    chk("err_cleared", err, 1'b0);
    rst = 1'b1;
    #1;

    // Randomized stall/redirect/latency against the stream model
    fill_mem();
    do_reset();
    rand_lat   = 1;
    exp_pc     = 16'h0000;
    prev_pend  = 0;
    prev_redir = 0;
    prev_addr  = 16'h0000;
    ref_err    = 0;
    consumed   = 0;
    model_on   = 1;
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = 16'($urandom_range(0, 1023) * 2);
      if ($urandom_range(0, 15) == 0) rpc[0] = 1'b1;
      step(st, rd, rpc);
    end
    model_on = 0;
    chk("rand_progress", consumed > 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the five-stage pipelined processor, directly upstream of `instr_decode`. Owns the PC and issues 16-bit instruction reads to a variable-latency instruction memory. Holds the IF/ID pipeline register that feeds decode, with stall, redirect (branch/jump) and halt handling. Uses a one-entry skid buffer so memory responses are never lost while decode is stalled.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `imem_req` in→out 1: read request; forced 0 while `rst` low.
- `imem_addr` out 16: read address; stable while `imem_req` high and `imem_ready` low.
- `imem_ready` in 1: response valid this cycle; data on `imem_rdata`. May be high in the same cycle as the request.
- `imem_rdata` in 16: instruction word.
- `stall` in 1: hazard unit; hold IF/ID contents.
- `redirect` in 1: taken branch/jump/JR; squash IF/ID and refetch.
- `redirect_pc` in 16: target PC, valid with `redirect`.
- `if_instr` out 16: IF/ID instruction, goes to decode `instruction`.
- `if_pc_plus2` out 16: PC+2 of `if_instr`.
- `if_valid` out 1: IF/ID holds a real instruction.
- `if_HALT` out 1: `if_valid` and `if_instr[15:11]`==5'b00000, goes to decode `id_HALT`.
- `err` out 1: sticky misaligned-PC error.

## Operation
- States: REQ, HOLD, DRAIN, HALTED.
- A response is accepted when `imem_req` && `imem_ready`.
- Registered skid buffer: `buf_instr`, `buf_pc2`.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On accept:
  - `pc`←`pc`+2, mod 2^16, wraps 16'hFFFE→16'h0000.
  - If `stall`=0: load IF/ID. Go HALTED if the word's opcode is 00000, else stay in REQ.
  - If `stall`=1: capture into the buffer and go HOLD.
- HOLD: `imem_req`=0; IF/ID unchanged. When `stall`=0: load IF/ID from the buffer, then go HALTED if the buffered word is HALT, else REQ.
- HALTED: `imem_req`=0. Once `stall`=0 clears IF/ID (`if_valid`←0, `if_instr`←16'h0800 NOP), the stage stays idle.
- IF/ID while in REQ with `stall`=0 and no accept: becomes a bubble (`if_valid`=0, `if_instr`=16'h0800).
- `redirect` has highest priority, overriding `stall`:
  - IF/ID ← bubble; buffer dropped; `pc`←`redirect_pc`.
  - In REQ with no accept this cycle, go DRAIN.
  - In REQ with an accept, go REQ; the data is discarded.
  - From HOLD or HALTED, go REQ.
- DRAIN: keep `imem_req`=1 at the old address. On `imem_ready`, discard the data and go REQ. A further `redirect` in DRAIN updates `pc` only.
- `err`←1 when `redirect` && `redirect_pc[0]`; cleared only by reset. Fetch still proceeds with bit 0 forced to 0.
- Reset values: `pc`=`RESET_PC`, state=REQ, `if_valid`=0, `if_instr`=16'h0800, `if_pc_plus2`=0, `err`=0, buffer=0.

## Timing
- Zero-wait memory: accept in cycle n, IF/ID valid in n+1. Sustained rate is 1 instr/cycle, with no bubble on HOLD release.
- First request in the first cycle after `rst` rises.
- Redirect in cycle n:
  - `if_valid`=0 in n+1.
  - No DRAIN needed: target request in n+1, valid instruction in n+2 at the earliest.
  - DRAIN needed: target request in the cycle after the old `imem_ready`.
- `if_HALT` is derived combinationally from IF/ID registers only. No combinational path from `imem_rdata` to outputs.
- `imem_req`/`imem_addr` depend on state and `pc` only, with no combinational dependence on `stall`. Only `rst` gates `imem_req`.

## Structure
- Shared package holds:
  - `NOP_INSTR`=16'h0800
  - `OP_HALT`=5'b00000
  - fetch state enum (REQ, HOLD, DRAIN, HALTED)
- Sub-module `if_id_reg`: 33-bit register (instr, pc+2, valid) with load, bubble and hold controls. It is reused for later pipeline latches.

## Test plan
- Reset, `RESET_PC`=0, zero-wait memory returning 16'hC001, 16'hC102, 16'hC203 → `imem_addr` 0,2,4 on consecutive cycles; `if_instr` matches each word one cycle later; `if_pc_plus2` 2,4,6.
- `stall`=1 during the accept of 16'hC102 and held 3 cycles → HOLD, `imem_req`=0, IF/ID holds 16'hC001. On release, 16'hC102 appears once, then the addr-4 word; nothing lost or duplicated.
- 3-cycle memory; `redirect` to 16'h0040 one cycle into the request at 0x0008 → `imem_addr` stays 0x0008 until ready and the data is dropped. Next request is 0x0040, with `if_valid`=0 throughout.
- Memory returns 16'h0000 at 0x0006 → `if_HALT`=1 and `imem_req` stays 0. `redirect` to 16'h0010 → fetch resumes at 0x0010 and `if_HALT` drops.
- `redirect`, `stall` and `imem_ready` all high in the same cycle → IF/ID becomes a bubble, the response is discarded, and the next `imem_addr` is `redirect_pc`.
- `redirect_pc`=16'h0003 → `err`=1 and fetch proceeds at 0x0002. `err` stays set until `rst`=0 for one cycle.
